// File: rtl/reg_file_param.sv
// Parametrised single-clock register file with registered read port,
// same-address bypass, error strobe and a hardware clear sequencer.
module reg_file_param #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter int               ADDR_W    = 3,
  parameter logic [WIDTH-1:0] REG0_INIT = '0,
  parameter logic [WIDTH-1:0] REG1_INIT = '0,
  parameter bit               BYPASS    = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [WIDTH-1:0]  RdData,
  output logic              RdData_Valid,
  input  logic              Clr,
  output logic              Busy,
  output logic              Err,
  output logic [WIDTH-1:0]  REG0,
  output logic [WIDTH-1:0]  REG1
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_do_wr;
  logic              w_do_rd;
  logic              w_clr_wr;
  logic              w_err;
  logic [WIDTH-1:0]  w_rd_val;
  logic [WIDTH-1:0]  w_clr_val;

  assign w_wr_ok = ({1'b0, WrAddr} < LP_DEPTH);
  assign w_rd_ok = ({1'b0, RdAddr} < LP_DEPTH);

  // State register; reset abandons any clear in progress
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle access decisions
  always_comb begin
    w_state_nxt = r_state;
    w_do_wr     = 1'b0;
    w_do_rd     = 1'b0;
    w_clr_wr    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Clr) begin
          w_state_nxt = S_CLEAR;
          w_err       = WrEn | RdEn;
        end else begin
          w_do_wr = WrEn & w_wr_ok;
          w_do_rd = RdEn;
          w_err   = (WrEn & ~w_wr_ok)
                  | (RdEn & ~w_rd_ok);
        end
      end
      S_CLEAR: begin
        w_clr_wr = 1'b1;
        w_err    = WrEn | RdEn;
        if (r_cnt == LP_LAST)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read mux: out-of-range reads return zero, bypass on same address
  always_comb begin
    w_rd_val = '0;
    if (w_rd_ok) begin
      if (BYPASS && w_do_wr && (WrAddr == RdAddr))
        w_rd_val = WrData;
      else
        w_rd_val = r_mem[RdAddr];
    end
  end

  // Init value of the entry the clear sequencer is currently writing
  always_comb begin
    w_clr_val = '0;
    if (r_cnt == ADDR_W'(0))      w_clr_val = REG0_INIT;
    else if (r_cnt == ADDR_W'(1)) w_clr_val = REG1_INIT;
  end

  // Clear counter walks every entry once, then rests at zero
  always_ff @(posedge CLK) begin
    if (RST)
      r_cnt <= '0;
    else if (r_state == S_CLEAR)
      r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
  end

  // Storage array; clear writes take the place of user writes
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 0)      r_mem[i] <= REG0_INIT;
        else if (i == 1) r_mem[i] <= REG1_INIT;
        else             r_mem[i] <= '0;
      end
    end else if (w_clr_wr) begin
      r_mem[r_cnt] <= w_clr_val;
    end else if (w_do_wr) begin
      r_mem[WrAddr] <= WrData;
    end
  end

  // Registered read data, valid strobe and error strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_do_rd) r_rd_data <= w_rd_val;
      r_rd_valid <= w_do_rd;
      r_err      <= w_err;
    end
  end

  assign RdData       = r_rd_data;
  assign RdData_Valid = r_rd_valid;
  assign Err          = r_err;
  assign Busy         = (r_state == S_CLEAR);
  assign REG0         = r_mem[0];
  assign REG1         = r_mem[1];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: three instances share stimulus
// (bypass, no-bypass, and a 6-entry non-power-of-two depth).
module tb_reg_file_param;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WrEn;
  logic [2:0]  WrAddr;
  logic [15:0] WrData;
  logic        RdEn;
  logic [2:0]  RdAddr;
  logic        Clr;

  logic [15:0] rd0, rd1, rd2;
  logic        vl0, vl1, vl2;
  logic        bz0, bz1, bz2;
  logic        er0, er1, er2;
  logic [15:0] g00, g01, g10, g11, g20, g21;

  int n_err = 0;
  int n_chk = 0;

  always #5 CLK = ~CLK;

  reg_file_param #(
    .WIDTH(16), .DEPTH(8), .ADDR_W(3),
    .REG0_INIT(16'hA5A5), .REG1_INIT(16'h0003), .BYPASS(1'b1)
  ) u0 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .RdEn(RdEn), .RdAddr(RdAddr),
    .RdData(rd0), .RdData_Valid(vl0), .Clr(Clr), .Busy(bz0),
    .Err(er0), .REG0(g00), .REG1(g01)
  );

  reg_file_param #(
    .WIDTH(16), .DEPTH(8), .ADDR_W(3),
    .REG0_INIT(16'hA5A5), .REG1_INIT(16'h0003), .BYPASS(1'b0)
  ) u1 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .RdEn(RdEn), .RdAddr(RdAddr),
    .RdData(rd1), .RdData_Valid(vl1), .Clr(Clr), .Busy(bz1),
    .Err(er1), .REG0(g10), .REG1(g11)
  );

  reg_file_param #(
    .WIDTH(16), .DEPTH(6), .ADDR_W(3),
    .REG0_INIT(16'hA5A5), .REG1_INIT(16'h0003), .BYPASS(1'b1)
  ) u2 (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .RdEn(RdEn), .RdAddr(RdAddr),
    .RdData(rd2), .RdData_Valid(vl2), .Clr(Clr), .Busy(bz2),
    .Err(er2), .REG0(g20), .REG1(g21)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic we,
                     input logic [2:0] wa, input logic [15:0] wd,
                     input logic re, input logic [2:0] ra,
                     input logic clr);
    RST = rst; WrEn = we; WrAddr = wa; WrData = wd;
    RdEn = re; RdAddr = ra; Clr = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 0);
  endtask

  task automatic fill_ff();
    for (int a = 0; a < 8; a++)
      cyc(0, 1, 3'(a), 16'h00FF, 0, 3'd0, 0);
  endtask

  initial begin
    // reset
    cyc(1, 0, 3'd0, 16'h0, 0, 3'd0, 0);
    chk("rst_reg0", g00, 16'hA5A5);
    chk("rst_reg1", g01, 16'h0003);
    chk("rst_rddata", rd0, 16'h0000);
    chk("rst_valid", 16'(vl0), 16'h0);
    chk("rst_busy", 16'(bz0), 16'h0);
    chk("rst_err", 16'(er0), 16'h0);

    cyc(0, 0, 3'd0, 16'h0, 1, 3'd5, 0);
    chk("rd5_data", rd0, 16'h0000);
    chk("rd5_valid", 16'(vl0), 16'h1);

    // write then read back
    cyc(0, 1, 3'd3, 16'h1234, 0, 3'd0, 0);
    chk("wr3_valid", 16'(vl0), 16'h0);
    chk("wr3_err", 16'(er0), 16'h0);
    cyc(0, 0, 3'd0, 16'h0, 1, 3'd3, 0);
    chk("rd3_data", rd0, 16'h1234);
    chk("rd3_valid", 16'(vl0), 16'h1);
    chk("rd3_err", 16'(er0), 16'h0);
    idle();
    chk("rd3_valid_drop", 16'(vl0), 16'h0);
    chk("rd3_hold", rd0, 16'h1234);

    // simultaneous same-address write/read
    cyc(0, 1, 3'd2, 16'hBEEF, 1, 3'd2, 0);
    chk("byp_on", rd0, 16'hBEEF);
    chk("byp_off", rd1, 16'h0000);
    chk("byp_off_valid", 16'(vl1), 16'h1);
    cyc(0, 0, 3'd0, 16'h0, 1, 3'd2, 0);
    chk("byp_off_after", rd1, 16'hBEEF);

    // out of range on the 6-entry instance
    cyc(0, 1, 3'd7, 16'hFFFF, 0, 3'd0, 0);
    chk("oor_wr_err", 16'(er2), 16'h1);
    chk("inr_wr_err", 16'(er0), 16'h0);
    cyc(0, 0, 3'd0, 16'h0, 1, 3'd6, 0);
    chk("oor_rd_data", rd2, 16'h0000);
    chk("oor_rd_valid", 16'(vl2), 16'h1);
    chk("oor_rd_err", 16'(er2), 16'h1);
    cyc(0, 0, 3'd0, 16'h0, 1, 3'd3, 0);
    chk("oor_keep3", rd2, 16'h1234);
    chk("oor_err_end", 16'(er2), 16'h0);
    chk("oor_reg0", g20, 16'hA5A5);
    chk("oor_reg1", g21, 16'h0003);
    cyc(0, 1, 3'd7, 16'hFFFF, 1, 3'd6, 0);
    chk("oor_both_err", 16'(er2), 16'h1);
    idle();
    chk("oor_both_single", 16'(er2), 16'h0);

    // clear sequence
    fill_ff();
    chk("fill_reg0", g00, 16'h00FF);
    chk("fill_reg1", g01, 16'h00FF);
    cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 1);
    chk("clr_busy_0", 16'(bz0), 16'h1);
    chk("clr_err_0", 16'(er0), 16'h0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        cyc(0, 1, 3'd4, 16'h1111, 0, 3'd0, 0);
        chk("clr_wr_err", 16'(er0), 16'h1);
        chk("clr_wr_valid", 16'(vl0), 16'h0);
      end else begin
        idle();
      end
      chk($sformatf("clr_busy_%0d", k), 16'(bz0),
          (k < 8) ? 16'h1 : 16'h0);
    end
    chk("clr_reg0", g00, 16'hA5A5);
    chk("clr_reg1", g01, 16'h0003);
    cyc(0, 0, 3'd0, 16'h0, 1, 3'd4, 0);
    chk("clr_e4", rd0, 16'h0000);
    cyc(0, 0, 3'd0, 16'h0, 1, 3'd7, 0);
    chk("clr_e7", rd0, 16'h0000);

    // reset during clear, then restart
    fill_ff();
    cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, 1);
    idle();
    idle();
    cyc(1, 0, 3'd0, 16'h0, 0, 3'd0, 0);
    chk("rstc_busy", 16'(bz0), 16'h0);
    chk("rstc_reg0", g00, 16'hA5A5);
    chk("rstc_reg1", g01, 16'h0003);
    cyc(0, 0, 3'd0, 16'h0, 1, 3'd5, 0);
    chk("rstc_e5", rd0, 16'h0000);
    chk("rstc_e5_valid", 16'(vl0), 16'h1);
    cyc(0, 1, 3'd0, 16'h00FF, 0, 3'd0, 0);
    chk("rstc_wr0", g00, 16'h00FF);
    cyc(0, 1, 3'd1, 16'h7777, 0, 3'd0, 1);
    chk("rclr_err", 16'(er0), 16'h1);
    chk("rclr_busy", 16'(bz0), 16'h1);
    chk("rclr_valid", 16'(vl0), 16'h0);
    chk("rclr_wr_drop", g01, 16'h0003);
    idle();
    chk("rclr_e0_first", g00, 16'hA5A5);
    for (int k = 0; k < 7; k++) idle();
    chk("rclr_done", 16'(bz0), 16'h0);
    chk("rclr_reg1", g01, 16'h0003);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
